// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the IF/MEM memory bus arbiter.
package mem_bus_arbiter_pkg;

    localparam logic Chip_Enable  = 1'b1;
    localparam logic Write_Enable = 1'b1;

    // Wide enough for TIMEOUT up to 1023
    localparam int unsigned TMO_W = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        OWN_DM = 1'b0,
        OWN_IF = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_bus_arbiter_timeout_counter.sv
// Bus-transfer watchdog: counts enabled cycles and flags the last allowed one.
module timeout_counter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic hit_o
);

    logic [TMO_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Hit in the TIMEOUT-th enabled cycle, so the abort lands on its closing edge
    assign hit_o = en_i && (cnt_q == TMO_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Serialises data-port and fetch-port accesses onto one handshaked bus,
// buffering read data and stalling the pipeline until both are served.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_ce_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              dm_ce_i,
    input  logic              dm_we_i,
    input  logic [3:0]        dm_sel_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    input  logic              hold_i,
    input  logic              flush_i,
    output logic              stallreq_o,
    output logic              bus_cyc_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_sel_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic              bus_err_o
);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              dm_done_q, dm_done_d;
    logic              if_done_q, if_done_d;
    logic              discard_q, discard_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              cyc_q, cyc_d;
    logic              we_q, we_d;
    logic [3:0]        sel_q, sel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;

    logic              dm_pend, if_pend, tmo_hit;
    logic [DATA_W-1:0] xfer_data;

    timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk   (clk),
        .rst   (rst),
        .en_i  (state_q == BUSY),
        .clr_i (state_q != BUSY),
        .hit_o (tmo_hit)
    );

    assign dm_pend    = (dm_ce_i == Chip_Enable) & ~dm_done_q;
    assign if_pend    = (if_ce_i == Chip_Enable) & ~if_done_q;
    assign stallreq_o = dm_pend | if_pend;
    assign xfer_data  = bus_ack_i ? bus_rdata_i : '0;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        dm_done_d  = dm_done_q;
        if_done_d  = if_done_q;
        discard_d  = discard_q;
        dm_rdata_d = dm_rdata_q;
        if_rdata_d = if_rdata_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (flush_i) begin
                    dm_done_d = 1'b0;
                    if_done_d = 1'b0;
                end else if (dm_pend) begin
                    cyc_d     = 1'b1;
                    we_d      = (dm_we_i == Write_Enable);
                    sel_d     = dm_sel_i;
                    addr_d    = dm_addr_i;
                    wdata_d   = dm_wdata_i;
                    owner_d   = OWN_DM;
                    discard_d = 1'b0;
                    state_d   = BUSY;
                end else if (if_pend) begin
                    cyc_d     = 1'b1;
                    we_d      = 1'b0;
                    sel_d     = 4'b1111;
                    addr_d    = if_addr_i;
                    wdata_d   = '0;
                    owner_d   = OWN_IF;
                    discard_d = 1'b0;
                    state_d   = BUSY;
                end else if (dm_done_q | if_done_q) begin
                    state_d = DONE;
                end
            end
            BUSY: begin
                if (flush_i) begin
                    discard_d = 1'b1;
                end
                if (bus_ack_i | tmo_hit) begin
                    cyc_d     = 1'b0;
                    discard_d = 1'b0;
                    err_d     = ~bus_ack_i;
                    state_d   = IDLE;
                    // A flushed transfer also invalidates whatever the other port completed
                    if (discard_q | flush_i) begin
                        dm_done_d = 1'b0;
                        if_done_d = 1'b0;
                    end else if (owner_q == OWN_DM) begin
                        dm_done_d  = 1'b1;
                        dm_rdata_d = we_q ? '0 : xfer_data;
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = xfer_data;
                    end
                end
            end
            DONE: begin
                if (flush_i | (~stallreq_o & ~hold_i)) begin
                    dm_done_d = 1'b0;
                    if_done_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_DM;
            dm_done_q  <= 1'b0;
            if_done_q  <= 1'b0;
            discard_q  <= 1'b0;
            dm_rdata_q <= '0;
            if_rdata_q <= '0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            dm_done_q  <= dm_done_d;
            if_done_q  <= if_done_d;
            discard_q  <= discard_d;
            dm_rdata_q <= dm_rdata_d;
            if_rdata_q <= if_rdata_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
        end
    end

    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign bus_cyc_o   = cyc_q;
    assign bus_we_o    = we_q;
    assign bus_sel_o   = sel_q;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;
    assign bus_err_o   = err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus queues expected bus cycles and
// per-instruction results; a monitor checks them as the DUT presents them.
module tb_mem_bus_arbiter;

    localparam int unsigned TMO   = 4;
    localparam int unsigned NEVER = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_ce_i, dm_ce_i, dm_we_i, hold_i, flush_i;
    logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i;
    logic [3:0]  dm_sel_i;
    logic [31:0] if_rdata_o, dm_rdata_o;
    logic        stallreq_o, bus_cyc_o, bus_we_o, bus_err_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
        .dm_ce_i(dm_ce_i), .dm_we_i(dm_we_i), .dm_sel_i(dm_sel_i),
        .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i), .dm_rdata_o(dm_rdata_o),
        .hold_i(hold_i), .flush_i(flush_i), .stallreq_o(stallreq_o),
        .bus_cyc_o(bus_cyc_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          chk_wd;
    } bus_t;

    typedef struct {
        bit          chk;
        bit          dm_en;
        bit          if_en;
        logic [31:0] dm_rd;
        logic [31:0] if_rd;
        int unsigned stall;
    } res_t;

    bus_t        bus_q[$];
    res_t        res_q[$];
    int unsigned lat_q[$];
    logic [31:0] ref_mem[int unsigned];
    logic [31:0] slv_mem[int unsigned];
    int unsigned n_chk = 0, n_fail = 0;
    logic [31:0] last_if = '0, last_dm = '0;
    bit          stray = 1'b0;

    function automatic logic [31:0] dflt(int unsigned w);
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // sel[3] is byte 0 = bits 31:24
    function automatic logic [31:0] merge(logic [31:0] old, logic [3:0] sel, logic [31:0] d);
        for (int i = 0; i < 4; i++)
            if (sel[3-i]) old[31-8*i -: 8] = d[31-8*i -: 8];
        return old;
    endfunction

    function automatic logic [31:0] ref_rd(logic [31:0] a);
        int unsigned w = a >> 2;
        return ref_mem.exists(w) ? ref_mem[w] : dflt(w);
    endfunction

    function automatic logic [31:0] slv_rd(logic [31:0] a);
        int unsigned w = a >> 2;
        return slv_mem.exists(w) ? slv_mem[w] : dflt(w);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic preset(logic [31:0] a, logic [31:0] d);
        ref_mem[a >> 2] = d;
        slv_mem[a >> 2] = d;
    endtask

    // Slave: memory with per-transfer latency taken from lat_q (empty = never acks)
    initial begin
        int unsigned busy_cnt = 0;
        int unsigned cur_lat  = 0;
        bus_ack_i   = 1'b0;
        bus_rdata_i = '0;
        forever begin
            @(posedge clk); #2;
            bus_ack_i   = 1'b0;
            bus_rdata_i = '0;
            if (!bus_cyc_o) begin
                busy_cnt = 0;
                if (stray) begin
                    bus_ack_i   = 1'b1;
                    bus_rdata_i = 32'hBAD0_BAD0;
                end
            end else begin
                if (busy_cnt == 0) cur_lat = (lat_q.size() != 0) ? lat_q.pop_front() : NEVER;
                if (busy_cnt == cur_lat) begin
                    bus_ack_i = 1'b1;
                    if (bus_we_o) slv_mem[bus_addr_o >> 2] = merge(slv_rd(bus_addr_o), bus_sel_o, bus_wdata_o);
                    else          bus_rdata_i = slv_rd(bus_addr_o);
                    busy_cnt = 0;
                end else begin
                    busy_cnt++;
                end
            end
        end
    end

    // Monitor: bus request fields on each new cycle, results when stall ends
    initial begin
        int unsigned scnt = 0;
        bit          cyc_prev = 1'b0;
        bus_t        eb;
        res_t        er;
        forever begin
            @(negedge clk);
            if (bus_cyc_o && !cyc_prev) begin
                if (bus_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL bus_unexpected: cycle to 0x%08h, expected none", bus_addr_o);
                end else begin
                    eb = bus_q.pop_front();
                    check("bus_addr", bus_addr_o, eb.addr);
                    check("bus_we", 32'(bus_we_o), 32'(eb.we));
                    check("bus_sel", 32'(bus_sel_o), 32'(eb.sel));
                    if (eb.chk_wd) check("bus_wdata", bus_wdata_o, eb.wdata);
                end
            end
            cyc_prev = bus_cyc_o;
            if (stallreq_o) begin
                scnt++;
            end else if (scnt != 0) begin
                if (res_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL res_unexpected: stall of %0d cycles, expected none", scnt);
                end else begin
                    er = res_q.pop_front();
                    if (er.chk) begin
                        if (er.dm_en) check("dm_rdata", dm_rdata_o, er.dm_rd);
                        if (er.if_en) check("if_rdata", if_rdata_o, er.if_rd);
                        check("stall_len", scnt, er.stall);
                    end
                end
                scnt = 0;
            end
        end
    end

    task automatic issue(bit dm_en, bit we, logic [3:0] sel, logic [31:0] dm_addr,
                         logic [31:0] wdata, bit if_en, logic [31:0] if_addr,
                         int unsigned lat_dm, int unsigned lat_if, bit chk);
        res_t r;
        r.chk = chk; r.dm_en = dm_en; r.if_en = if_en;
        r.dm_rd = '0; r.if_rd = '0; r.stall = 0;
        if (dm_en) begin
            bus_q.push_back('{we, sel, dm_addr, wdata, we});
            if (lat_dm == NEVER) begin
                r.stall += 1 + TMO;
            end else begin
                lat_q.push_back(lat_dm);
                r.stall += 2 + lat_dm;
                if (we) ref_mem[dm_addr >> 2] = merge(ref_rd(dm_addr), sel, wdata);
                else    r.dm_rd = ref_rd(dm_addr);
            end
            last_dm = r.dm_rd;
        end
        if (if_en) begin
            bus_q.push_back('{1'b0, 4'hF, if_addr, 32'h0, 1'b0});
            if (lat_if == NEVER) begin
                r.stall += 1 + TMO;
            end else begin
                lat_q.push_back(lat_if);
                r.stall += 2 + lat_if;
                r.if_rd = ref_rd(if_addr);
            end
            last_if = r.if_rd;
        end
        res_q.push_back(r);
        dm_ce_i = dm_en; dm_we_i = we; dm_sel_i = sel; dm_addr_i = dm_addr; dm_wdata_i = wdata;
        if_ce_i = if_en; if_addr_i = if_addr;
    endtask

    task automatic wait_done();
        int unsigned n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stallreq_o && n < 200);
        if (stallreq_o) begin
            n_chk++; n_fail++;
            $display("FAIL wait_done: stallreq_o still 1 after %0d cycles, expected 0", n);
        end
    endtask

    task automatic finish_txn(int unsigned hold_cyc);
        if (hold_cyc != 0) begin
            @(posedge clk); #1;
            hold_i = 1'b1;
            for (int unsigned i = 0; i < hold_cyc; i++) begin
                @(negedge clk);
                check("hold_cyc", 32'(bus_cyc_o), 32'h0);
                check("hold_stall", 32'(stallreq_o), 32'h0);
                check("hold_if_rdata", if_rdata_o, last_if);
                check("hold_dm_rdata", dm_rdata_o, last_dm);
            end
        end
        @(posedge clk); #1;
        hold_i = 1'b0; dm_ce_i = 1'b0; if_ce_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prev_if;
        int unsigned ncyc, nerr, n;
        bit          den, dwe;
        logic [3:0]  dsel;

        rst = 1'b1; if_ce_i = 0; dm_ce_i = 0; dm_we_i = 0; hold_i = 0; flush_i = 0;
        dm_sel_i = '0; if_addr_i = '0; dm_addr_i = '0; dm_wdata_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_if_rdata", if_rdata_o, 32'h0);
        check("rst_dm_rdata", dm_rdata_o, 32'h0);
        check("rst_cyc", 32'(bus_cyc_o), 32'h0);
        check("rst_bus_addr", bus_addr_o, 32'h0);
        check("rst_stall", 32'(stallreq_o), 32'h0);
        check("rst_err", 32'(bus_err_o), 32'h0);
        @(posedge clk); #1;

        // Fetch only, zero-wait
        preset(32'h100, 32'hDEAD_BEEF);
        issue(0, 0, 4'h0, 32'h0, 32'h0, 1, 32'h100, 0, 0, 1);
        wait_done(); finish_txn(0);

        // Both ports in one cycle: data first
        issue(1, 0, 4'hF, 32'h200, 32'h0, 1, 32'h104, 0, 0, 1);
        wait_done(); finish_txn(0);

        // Byte store then read back with hold after completion
        issue(1, 1, 4'b0100, 32'h301, 32'h4444_4444, 0, 32'h0, 0, 0, 1);
        wait_done(); finish_txn(0);
        issue(1, 0, 4'hF, 32'h300, 32'h0, 1, 32'h108, 1, 0, 1);
        wait_done(); finish_txn(3);

        // Stray ack while idle must be ignored
        stray = 1'b1;
        @(posedge clk); #1 stray = 1'b0;
        @(negedge clk);
        check("stray_cyc", 32'(bus_cyc_o), 32'h0);
        check("stray_if_rdata", if_rdata_o, last_if);
        check("stray_dm_rdata", dm_rdata_o, last_dm);
        @(posedge clk); #1;

        // Flush during BUSY, ack two cycles later: discarded then re-fetched
        preset(32'h500, 32'h1234_5678);
        prev_if = last_if;
        bus_q.push_back('{1'b0, 4'hF, 32'h500, 32'h0, 1'b0});
        bus_q.push_back('{1'b0, 4'hF, 32'h500, 32'h0, 1'b0});
        lat_q.push_back(2); lat_q.push_back(0);
        res_q.push_back('{1'b1, 1'b0, 1'b1, 32'h0, 32'h1234_5678, 6});
        last_if = 32'h1234_5678;
        if_ce_i = 1'b1; if_addr_i = 32'h500;
        @(posedge clk); #1 flush_i = 1'b1;
        @(posedge clk); #1 flush_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("flush_discard_rdata", if_rdata_o, prev_if);
        check("flush_still_stall", 32'(stallreq_o), 32'h1);
        check("flush_idle_cyc", 32'(bus_cyc_o), 32'h0);
        wait_done(); finish_txn(0);

        // Slave never acks: abort after TMO busy cycles with one error pulse
        issue(0, 0, 4'h0, 32'h0, 32'h0, 1, 32'h10C, 0, NEVER, 1);
        ncyc = 0; nerr = 0; n = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus_cyc_o) ncyc++;
            if (bus_err_o) nerr++;
        end while (stallreq_o && n < 200);
        check("tmo_cyc_len", ncyc, TMO);
        check("tmo_err_pulses", nerr, 1);
        finish_txn(0);
        @(negedge clk);
        check("tmo_err_after", 32'(bus_err_o), 32'h0);
        @(posedge clk); #1;

        // Randomised traffic against the memory model
        for (int unsigned t = 0; t < 40; t++) begin
            den  = $urandom_range(0, 1);
            dwe  = $urandom_range(0, 1);
            dsel = dwe ? 4'($urandom_range(1, 15)) : 4'hF;
            issue(den, dwe, dsel,
                  32'h400 + ($urandom_range(0, 15) << 2) + (dwe ? $urandom_range(0, 3) : 0),
                  $urandom(),
                  den ? bit'($urandom_range(0, 1)) : 1'b1,
                  32'h400 + ($urandom_range(0, 15) << 2),
                  $urandom_range(0, 2), $urandom_range(0, 2), 1);
            wait_done();
            finish_txn(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end

        // Reset mid-transfer drops the bus without an ack
        issue(0, 0, 4'h0, 32'h0, 32'h0, 1, 32'h600, 0, NEVER, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; if_ce_i = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_cyc", 32'(bus_cyc_o), 32'h0);
        check("rst_mid_if_rdata", if_rdata_o, 32'h0);
        rst = 1'b0; last_if = '0; last_dm = '0;
        @(posedge clk); #1;
        issue(0, 0, 4'h0, 32'h0, 32'h0, 1, 32'h604, 0, 1, 1);
        wait_done(); finish_txn(0);

        repeat (3) @(posedge clk);
        check("bus_q_empty", bus_q.size(), 0);
        check("res_q_empty", res_q.size(), 0);
        check("lat_q_empty", lat_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares one single-ported, handshaked memory bus between the instruction-fetch port and the data port driven by the MEM stage. The block serialises the two requests, with the data port first. It buffers each port's read data until the pipeline advances, and it raises one stall request to the pipeline controller while any requested access is still outstanding. It sits between the core's IF/MEM stages and the external RAM/bus slave.

## Interface
Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width. Must be 32; byte selects are 4 bits.
- TIMEOUT, 255, maximum cycles a transfer waits for ack before it is aborted. Range 1..1023.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- if_ce_i  in  1  fetch request valid (read only).
- if_addr_i  in  ADDR_W  fetch address.
- if_rdata_o  out  DATA_W  fetch data, valid while if_done.
- dm_ce_i  in  1  data request valid.
- dm_we_i  in  1  1 = write.
- dm_sel_i  in  4  byte enables, MSB = byte 0 (big-endian lanes).
- dm_addr_i  in  ADDR_W  data address.
- dm_wdata_i  in  DATA_W  write data.
- dm_rdata_o  out  DATA_W  read data, valid while dm_done.
- hold_i  in  1  pipeline stalled by a source other than this block.
- flush_i  in  1  pipeline flush.
- stallreq_o  out  1  stall request to the pipeline controller.
- bus_cyc_o  out  1  transfer active, registered.
- bus_we_o  out  1  registered.
- bus_sel_o  out  4  registered.
- bus_addr_o  out  ADDR_W  registered.
- bus_wdata_o  out  DATA_W  registered.
- bus_ack_i  in  1  slave completes the transfer this cycle.
- bus_rdata_i  in  DATA_W  valid with bus_ack_i.
- bus_err_o  out  1  one-cycle pulse on timeout.

## Operation
- State machine states: IDLE, BUSY, DONE.
- Completion flags: dm_done and if_done. Grant register: owner ∈ {DM, IF}. Discard flag.
- IDLE:
  - If dm_ce_i & ~dm_done: latch the dm request onto the bus registers, owner=DM, go to BUSY.
  - Else if if_ce_i & ~if_done: latch the fetch request (we=0, sel=4'b1111), owner=IF, go to BUSY.
  - Else if any flag is set: go to DONE.
- BUSY:
  - bus_cyc_o=1 and all bus fields are held stable.
  - On bus_ack_i: capture bus_rdata_i into the owner's buffer, set the owner's done flag, drop bus_cyc_o at the same edge, go to IDLE. IDLE then serves the other port if it is still pending.
- DONE:
  - Buffers and flags are held.
  - When ~stallreq_o & ~hold_i: clear both flags and go to IDLE. The pipeline advances at this edge.
- stallreq_o = (dm_ce_i & ~dm_done) | (if_ce_i & ~if_done). It is combinational and never depends on hold_i.
- Flush:
  - flush_i clears both flags at the next edge and sets the state to IDLE, except in BUSY.
  - In BUSY, the transfer runs to ack or timeout with discard=1. The captured data is dropped, no done flag is set, and the state goes to IDLE.
- Timeout:
  - A counter starts at 0 on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT without ack: drop bus_cyc_o, write 0 to the owner's buffer, set its done flag, pulse bus_err_o, go to IDLE.
- Write transfers set dm_done on ack. dm_rdata_o is then 0.

## Timing
- Reset value of every output is 0: rdata buffers, bus_* registers, bus_err_o, and stallreq_o (because the flags are cleared). State = IDLE, counter = 0.
- Request seen in cycle 0 (IDLE). bus_cyc_o is high in cycle 1.
- With ack in cycle 1 (zero-wait slave), data is in the buffer and stallreq_o is low in cycle 2.
- Minimum stall for a single port: 2 cycles. For both ports: 4 cycles.
- ack while bus_cyc_o=0 is ignored.
- rst mid-transfer drops bus_cyc_o at the next edge without waiting for ack.
- If flush_i and ack arrive in the same cycle in BUSY, the data is discarded.

## Structure
- Shared package:
  - State encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2).
  - Owner encoding.
  - `Chip_Enable`/`Write_Enable` constants from define.v.
- Sub-module timeout_counter (enable, clear, hit). All other logic stays flat.

## Test plan
- Fetch only: if_ce=1, addr 0x100. Slave acks the cycle after cyc with 0xDEADBEEF. Required: stallreq high 2 cycles, then if_rdata_o=0xDEADBEEF.
- Both ports: dm lw addr 0x200 and fetch 0x104, both in the same cycle. Required: bus shows 0x200 first, then 0x104. stallreq drops only after the second ack.
- Store: dm sb, sel=4'b0100, wdata=0x44444444, addr 0x301. Required: bus_we_o=1, sel 0100, addr 0x301.
- hold_i=1 for 3 cycles after completion. Required: state stays DONE, no re-issue, rdata stable.
- flush_i in BUSY, ack 2 cycles later with 0x12345678. Required: data discarded, next request re-issued from IDLE.
- Slave never acks, TIMEOUT=4. Required: cyc drops after 4 BUSY cycles, bus_err_o pulses once, rdata=0.
